mp3player_soc_onchip_memory_pipe: RTL
=====================================

MP3PLAYER_SOC_ONCHIP_MEMORY_PIPE -- requirements
Module: mp3player_soc_onchip_memory_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1024, word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 500, number of words.
REQ-003 SHALL have parameter ADDR_WIDTH, default 9, address bits; 2^ADDR_WIDTH >= DEPTH.
REQ-004 SHALL have parameter READ_LATENCY, default 2, accept-to-readdatavalid cycles; legal values are 1 and 2.
REQ-005 SHALL have parameter INIT_FILE, default "mp3player_soc_onchip_memory2_0.hex", initial contents; an empty string means no init.
REQ-006 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port reset_req, input, 1 bit: request to quiesce; blocks acceptance.
REQ-009 SHALL have port clken, input, 1 bit: acceptance enable.
REQ-010 SHALL have port chipselect, input, 1 bit: slave select.
REQ-011 SHALL have port read, input, 1 bit: read request.
REQ-012 SHALL have port write, input, 1 bit: write request.
REQ-013 SHALL have port address, input, ADDR_WIDTH bits: word address.
REQ-014 SHALL have port byteenable, input, DATA_WIDTH/8 bits: per-byte write enable.
REQ-015 SHALL have port writedata, input, DATA_WIDTH bits: write data.
REQ-016 SHALL have port waitrequest, output, 1 bit: request not accepted this cycle.
REQ-017 SHALL have port readdata, output, DATA_WIDTH bits: read data, registered.
REQ-018 SHALL have port readdatavalid, output, 1 bit: readdata and response valid.
REQ-019 SHALL have port response, output, 2 bits: 00 = OKAY, 10 = SLVERR.

Function
REQ-020 SHALL compute waitrequest combinationally as chipselect & (read | write) & (~clken | reset_req).
REQ-021 SHALL accept a request in a cycle where chipselect & (read | write) & ~waitrequest.
REQ-022 SHALL treat a request with read and write both high as a write; the read is dropped and no readdatavalid is produced.
REQ-023 SHALL, on an accepted write with address < DEPTH, update each byte i where byteenable[i]=1; bytes with byteenable[i]=0 SHALL be unchanged.
REQ-024 SHALL silently discard an accepted write with address >= DEPTH; memory SHALL be unchanged.
REQ-025 SHALL, for a read accepted in cycle N, assert readdatavalid for exactly one cycle at N+READ_LATENCY.
REQ-026 SHALL use a READ_LATENCY-deep pipeline of valid, error and data stages that advances every cycle, independent of clken and reset_req.
REQ-027 SHALL sustain one accepted read per cycle with no bubbles, returning results in issue order.
REQ-028 SHALL, for an in-range read, return the word contents as of the acceptance edge with response=00.
REQ-029 SHALL give write-then-read to the same address in consecutive cycles the new data.
REQ-030 SHALL, for an out-of-range read, return readdata=0 and response=10 with readdatavalid.
REQ-031 SHALL drive readdata and response to 0 in cycles where readdatavalid=0.
REQ-032 SHALL complete in-flight reads after clken or reset_req deasserts acceptance.

Reset
REQ-033 SHALL, on assertion of reset, immediately clear all pipeline valid bits and set readdatavalid=0, readdata=0 and response=00.
REQ-034 SHALL discard any read in flight when reset asserts; no readdatavalid SHALL be produced for it after reset releases.
REQ-035 SHALL NOT clear memory contents on reset.
REQ-036 SHALL have waitrequest depend only on its inputs, including during reset.

Verification (bench config: DATA_WIDTH=32, DEPTH=16, ADDR_WIDTH=5, READ_LATENCY=2, no INIT_FILE)
REQ-037 SHALL cover byte-enable: write 0xAABBCCDD to address 3 with be=1111, then 0x11223344 with be=0101, then read 3 -> readdata=0xAA22CC44 two cycles after accept, response=00.
REQ-038 SHALL cover back-to-back reads: reads to addresses 0..3 on 4 consecutive cycles -> readdatavalid high for 4 consecutive cycles starting 2 cycles later, data in order.
REQ-039 SHALL cover out of range: write 0xFFFFFFFF to address 20 then read 20 -> readdata=0, response=10; then read addresses 0..15 -> contents unchanged.
REQ-040 SHALL cover stall: clken=0 while read is pending -> waitrequest=1 and no readdatavalid; clken=1 -> accept, valid 2 cycles later; a read issued just before clken falls still returns.
REQ-041 SHALL cover reset mid-flight: issue read, then assert reset in the next cycle -> readdatavalid stays 0 through release; memory contents persist across reset.
REQ-042 SHALL cover read+write collision: read=1, write=1 at address 5 with data 0x5 -> no readdatavalid; a later read of 5 returns 0x5.

Source files
------------

// File: rtl/mp3player_soc_onchip_memory_pipe.sv
// Avalon-MM style on-chip RAM slave: byte-enabled writes, pipelined reads with
// a fixed READ_LATENCY and a SLVERR response for out-of-range words.
module mp3player_soc_onchip_memory_pipe #(
  parameter int DATA_WIDTH   = 1024,
  parameter int DEPTH        = 500,
  parameter int ADDR_WIDTH   = 9,
  parameter int READ_LATENCY = 2,
  parameter     INIT_FILE    = "mp3player_soc_onchip_memory2_0.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic                    clken,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic                    waitrequest,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic [1:0]              response
);

  localparam int BYTES = DATA_WIDTH / 8;
  // Sized to the full address space so every address indexes cleanly; words at
  // or above DEPTH are never written and never returned.
  localparam int WORDS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  request;
  logic                  accept;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  in_range;
  logic                  v0;
  logic                  e0;

  assign request     = chipselect & (read | write);
  assign waitrequest = request & (~clken | reset_req);
  assign accept      = request & ~waitrequest;
  assign wr_accept   = accept & write;
  assign rd_accept   = accept & read & ~write;
  assign in_range    = 32'(address) < DEPTH;

  // Storage is deliberately unreset so it maps onto block RAM and survives reset.
  always_ff @(posedge clk) begin
    if (wr_accept && in_range) begin
      for (int i = 0; i < BYTES; i++) begin
        if (byteenable[i]) mem[address][i*8 +: 8] <= writedata[i*8 +: 8];
      end
    end
    if (rd_accept) ram_q <= mem[address];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0 <= 1'b0;
      e0 <= 1'b0;
    end else begin
      v0 <= rd_accept;
      e0 <= rd_accept & ~in_range;
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign readdatavalid = v0;
      assign readdata      = (v0 && !e0) ? ram_q : '0;
      assign response      = {v0 & e0, 1'b0};
    end else begin : g_lat2
      logic                  v1;
      logic                  e1;
      logic [DATA_WIDTH-1:0] d1;

      // Data is zeroed on entry so idle and error cycles present readdata=0.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v1 <= 1'b0;
          e1 <= 1'b0;
          d1 <= '0;
        end else begin
          v1 <= v0;
          e1 <= v0 & e0;
          d1 <= (v0 && !e0) ? ram_q : '0;
        end
      end

      assign readdatavalid = v1;
      assign readdata      = d1;
      assign response      = {e1, 1'b0};
    end
  endgenerate

endmodule
